// File: rtl/sram_march_bist.sv
// rtl/sram_march_bist.sv - March C- BIST initiator for a single-port SRAM wrapper
// Optional SRAM_MARCH_BIST_DIAG_EN: run to completion on miscompare and count failures in fail_cnt.
module sram_march_bist #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter logic [DATA_W-1:0] BG0 = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act,
    output logic              sram_cen,
    output logic              sram_gwen,
    output logic [DATA_W-1:0] sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
`ifdef SRAM_MARCH_BIST_DIAG_EN
    ,
    output logic [15:0]       fail_cnt
`endif
);
    localparam logic [DATA_W-1:0] BG1 = ~BG0;
`ifdef SRAM_MARCH_BIST_DIAG_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, RWAIT, DONE} state_t;

    state_t            state;
    state_t            elem;
    logic [ADDR_W-1:0] addr;
    logic              wr_ph;
    logic [1:0]        wait_cnt;
    logic              failed;

    function automatic logic [DATA_W-1:0] rd_val(input state_t e);
        return (e == M2 || e == M4) ? BG1 : BG0;
    endfunction

    function automatic logic [DATA_W-1:0] wr_val(input state_t e);
        return (e == M1 || e == M3) ? BG1 : BG0;
    endfunction

    function automatic logic is_down(input state_t e);
        return (e == M3 || e == M4);
    endfunction

    function automatic state_t next_elem(input state_t e);
        case (e)
            M0:      return M1;
            M1:      return M2;
            M2:      return M3;
            M3:      return M4;
            M4:      return M5;
            default: return IDLE;
        endcase
    endfunction

    // cur is the element that owns the address counter, also while parked in RWAIT
    state_t            cur;
    state_t            nxt_e;
    logic              last_addr;
    logic [ADDR_W-1:0] nxt_a;
    logic              at_end;
    logic              op_done_wr;
    logic              rd_cmp;
    logic              fail_now;
    logic              abort;
    logic              do_adv;
    logic              do_fin;

    assign cur        = (state == RWAIT) ? elem : state;
    assign last_addr  = is_down(cur) ? (addr == '0) : (addr == {ADDR_W{1'b1}});
    assign nxt_e      = last_addr ? next_elem(cur) : cur;
    assign nxt_a      = last_addr ? (is_down(nxt_e) ? {ADDR_W{1'b1}} : '0)
                                  : (is_down(cur) ? addr - ADDR_W'(1) : addr + ADDR_W'(1));
    assign at_end     = last_addr && (cur == M5);
    assign op_done_wr = (state == M0) || (wr_ph && (state inside {M1, M2, M3, M4}));
    assign rd_cmp     = (state == RWAIT) && (wait_cnt == 2'd0);
    assign fail_now   = rd_cmp && (sram_q != rd_val(elem));
    assign abort      = fail_now && !DIAG;
    assign do_adv     = op_done_wr || (rd_cmp && elem == M5);
    assign do_fin     = abort || (do_adv && at_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            elem      <= IDLE;
            addr      <= '0;
            wr_ph     <= 1'b0;
            wait_cnt  <= 2'd0;
            failed    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
            sram_a    <= '0;
            sram_d    <= '0;
`ifdef SRAM_MARCH_BIST_DIAG_EN
            fail_cnt  <= '0;
`endif
        end else begin
            if (fail_now) begin
                failed <= 1'b1;
                if (!failed) begin
                    fail_addr <= addr;
                    fail_exp  <= rd_val(elem);
                    fail_act  <= sram_q;
                end
`ifdef SRAM_MARCH_BIST_DIAG_EN
                if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
`endif
            end
            if (do_fin) begin
                state     <= DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                pass      <= !(failed || fail_now);
                wr_ph     <= 1'b0;
                sram_cen  <= 1'b1;
                sram_gwen <= 1'b1;
                sram_wen  <= '1;
                sram_a    <= '0;
                sram_d    <= '0;
            end else if (do_adv) begin
                // only M0 writes first; every other element opens each address with a read
                state     <= nxt_e;
                addr      <= nxt_a;
                wr_ph     <= 1'b0;
                sram_cen  <= 1'b0;
                sram_a    <= nxt_a;
                sram_gwen <= (nxt_e != M0);
                sram_wen  <= (nxt_e == M0) ? '0 : '1;
                sram_d    <= (nxt_e == M0) ? BG0 : '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        state <= IDLE;
                        if (start) begin
                            state     <= M0;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            pass      <= 1'b0;
                            fail_addr <= '0;
                            fail_exp  <= '0;
                            fail_act  <= '0;
                            failed    <= 1'b0;
                            addr      <= '0;
                            wr_ph     <= 1'b0;
                            sram_cen  <= 1'b0;
                            sram_gwen <= 1'b0;
                            sram_wen  <= '0;
                            sram_a    <= '0;
                            sram_d    <= BG0;
`ifdef SRAM_MARCH_BIST_DIAG_EN
                            fail_cnt  <= '0;
`endif
                        end
                    end
                    M1, M2, M3, M4, M5: begin
                        state     <= RWAIT;
                        elem      <= state;
                        wait_cnt  <= 2'(RD_LAT - 1);
                        sram_cen  <= 1'b1;
                        sram_gwen <= 1'b1;
                        sram_wen  <= '1;
                    end
                    RWAIT: begin
                        if (wait_cnt != 2'd0) begin
                            wait_cnt <= wait_cnt - 2'd1;
                        end else begin
                            state     <= elem;
                            wr_ph     <= 1'b1;
                            sram_cen  <= 1'b0;
                            sram_gwen <= 1'b0;
                            sram_wen  <= '0;
                            sram_a    <= addr;
                            sram_d    <= wr_val(elem);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sram_march_bist.sv
// tb/tb_sram_march_bist.sv - scoreboard bench for sram_march_bist at RD_LAT 1 and 3
module tb_sram_march_bist;
`ifdef SRAM_MARCH_BIST_DIAG_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start3 = 1'b0;
    logic       fault_en = 1'b0;
    logic       busy1, done1, pass1, cen1, gwen1;
    logic       busy3, done3, pass3, cen3, gwen3;
    logic [8:0] fail_addr1, a1, fail_addr3, a3;
    logic [7:0] fail_exp1, fail_act1, wen1, d1, q1;
    logic [7:0] fail_exp3, fail_act3, wen3, d3, q3;
`ifdef SRAM_MARCH_BIST_DIAG_EN
    logic [15:0] fail_cnt1, fail_cnt3;
`endif

    sram_march_bist #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_addr(fail_addr1), .fail_exp(fail_exp1), .fail_act(fail_act1),
        .sram_cen(cen1), .sram_gwen(gwen1), .sram_wen(wen1), .sram_a(a1), .sram_d(d1), .sram_q(q1)
`ifdef SRAM_MARCH_BIST_DIAG_EN
        , .fail_cnt(fail_cnt1)
`endif
    );

    sram_march_bist #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3), .pass(pass3),
        .fail_addr(fail_addr3), .fail_exp(fail_exp3), .fail_act(fail_act3),
        .sram_cen(cen3), .sram_gwen(gwen3), .sram_wen(wen3), .sram_a(a3), .sram_d(d3), .sram_q(q3)
`ifdef SRAM_MARCH_BIST_DIAG_EN
        , .fail_cnt(fail_cnt3)
`endif
    );

    // SRAM models: Q carries read data only in the single cycle the BIST must sample it
    logic [7:0]  mem1 [512];
    logic [7:0]  mem3 [512];
    logic        pv1 = 1'b0;
    logic [7:0]  pd1 = 8'h00;
    logic [2:0]  pv3 = 3'b000;
    logic [23:0] pd3 = 24'h0;

    function automatic logic [7:0] rdv(input logic [7:0] m, input logic [8:0] a);
        return m | ((fault_en && a == 9'h0A5) ? 8'h08 : 8'h00);
    endfunction

    always @(posedge clk) begin
        if (!cen1 && !gwen1) mem1[a1] <= (mem1[a1] & wen1) | (d1 & ~wen1);
        pv1 <= !cen1 && gwen1;
        pd1 <= rdv(mem1[a1], a1);
        if (!cen3 && !gwen3) mem3[a3] <= (mem3[a3] & wen3) | (d3 & ~wen3);
        pv3 <= {pv3[1:0], !cen3 && gwen3};
        pd3 <= {pd3[15:0], rdv(mem3[a3], a3)};
    end
    assign q1 = pv1 ? pd1 : 8'h5A;
    assign q3 = pv3[2] ? pd3[23:16] : 8'h5A;

    // cen must stay high for RD_LAT cycles after every read issue
    int rwl1 = 0, viol1 = 0, rwl3 = 0, viol3 = 0;
    always @(posedge clk) begin
        if (rwl1 != 0) begin
            if (!cen1) viol1 <= viol1 + 1;
            rwl1 <= rwl1 - 1;
        end else if (!cen1 && gwen1) rwl1 <= 1;
        if (rwl3 != 0) begin
            if (!cen3) viol3 <= viol3 + 1;
            rwl3 <= rwl3 - 1;
        end else if (!cen3 && gwen3) rwl3 <= 3;
    end

    int bt1 = 0, bt3 = 0;
    always @(negedge clk) begin
        if (busy1) bt1 <= bt1 + 1;
        if (busy3) bt3 <= bt3 + 1;
    end

    typedef struct {
        int         cycles;
        logic       pass;
        logic [8:0] addr;
        logic [7:0] fexp;
        logic [7:0] fact;
        int         cnt;
    } exp_t;
    exp_t sb[$];

    int errors = 0, checks = 0;

    task automatic pulse1();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
    endtask

    task automatic wait_done(input bit use3, input int budget, output int cyc, output bit to);
        int b0;
        b0 = use3 ? bt3 : bt1;
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (use3 ? (done3 && !busy3) : (done1 && !busy1)) begin
                to = 1'b0;
                break;
            end
        end
        cyc = (use3 ? bt3 : bt1) - b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy1, done1, pass1, cen1, gwen1} !== 5'b00011) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00011", {busy1, done1, pass1, cen1, gwen1});
        end
        checks++;
        if ({fail_addr1, fail_exp1, fail_act1} !== 25'h0) begin
            errors++; $display("FAIL reset_fail: got %h expected 0", {fail_addr1, fail_exp1, fail_act1});
        end
        checks++;
        if ({wen1, a1, d1} !== {8'hFF, 17'h0}) begin
            errors++; $display("FAIL reset_bus: got %h expected %h", {wen1, a1, d1}, {8'hFF, 17'h0});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean();
        exp_t e;
        int cyc, v0;
        bit to;
        sb.push_back('{7680, 1'b1, 9'h0, 8'h0, 8'h0, 0});
        v0 = viol1;
        pulse1();
        wait_done(1'b0, 20000, cyc, to);
        e = sb.pop_front();
        checks++;
        if (to) begin errors++; $display("FAIL clean_timeout: done never rose"); end
        checks++;
        if (cyc != e.cycles) begin errors++; $display("FAIL clean_cycles: got %0d expected %0d", cyc, e.cycles); end
        checks++;
        if (pass1 !== e.pass || fail_addr1 !== e.addr) begin
            errors++; $display("FAIL clean_result: got pass=%b addr=%h expected pass=%b addr=%h", pass1, fail_addr1, e.pass, e.addr);
        end
        checks++;
        if (viol1 != v0 || cen1 !== 1'b1) begin
            errors++; $display("FAIL clean_cen: got viol=%0d cen=%b expected viol=0 cen=1", viol1 - v0, cen1);
        end
    endtask

    task automatic test_stuck_bit();
        exp_t e;
        int cyc;
        bit to;
        fault_en = 1'b1;
        sb.push_back('{DIAG ? 7680 : 512 + 3 * 9'h0A5 + 2, 1'b0, 9'h0A5, 8'h00, 8'h08, 3});
        pulse1();
        wait_done(1'b0, 20000, cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != e.cycles) begin
            errors++; $display("FAIL stuck_cycles: got %0d (timeout=%0b) expected %0d", cyc, to, e.cycles);
        end
        checks++;
        if (pass1 !== e.pass) begin errors++; $display("FAIL stuck_pass: got %b expected %b", pass1, e.pass); end
        checks++;
        if (fail_addr1 !== e.addr) begin errors++; $display("FAIL stuck_addr: got %h expected %h", fail_addr1, e.addr); end
        checks++;
        if (fail_exp1 !== e.fexp || fail_act1 !== e.fact) begin
            errors++; $display("FAIL stuck_data: got exp=%h act=%h expected exp=%h act=%h", fail_exp1, fail_act1, e.fexp, e.fact);
        end
`ifdef SRAM_MARCH_BIST_DIAG_EN
        checks++;
        if (fail_cnt1 !== 16'(e.cnt)) begin errors++; $display("FAIL stuck_cnt: got %0d expected %0d", fail_cnt1, e.cnt); end
`endif
        fault_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int cyc;
        bit to;
        pulse1();
        repeat (999) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy1, done1, cen1} !== 3'b001) begin
            errors++; $display("FAIL midrst_state: got busy,done,cen=%b expected 001", {busy1, done1, cen1});
        end
        rst_n = 1'b1;
        sb.push_back('{7680, 1'b1, 9'h0, 8'h0, 8'h0, 0});
        pulse1();
        wait_done(1'b0, 20000, cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != e.cycles || pass1 !== e.pass) begin
            errors++; $display("FAIL midrst_rerun: got cycles=%0d pass=%b expected cycles=%0d pass=%b", cyc, pass1, e.cycles, e.pass);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int cyc, b0;
        bit to;
        sb.push_back('{7680, 1'b1, 9'h0, 8'h0, 8'h0, 0});
        pulse1();
        b0 = bt1;
        to = 1'b1;
        for (int i = 1; i < 20000; i++) begin
            start1 = (i == 10 || i == 5000);
            @(negedge clk);
            if (done1 && !busy1) begin to = 1'b0; break; end
        end
        start1 = 1'b0;
        cyc = bt1 - b0;
        e = sb.pop_front();
        checks++;
        if (to || cyc != e.cycles || pass1 !== e.pass) begin
            errors++; $display("FAIL restart_ignored: got cycles=%0d pass=%b expected cycles=%0d pass=%b", cyc, pass1, e.cycles, e.pass);
        end
        sb.push_back('{7680, 1'b1, 9'h0, 8'h0, 8'h0, 0});
        pulse1();
        checks++;
        if ({done1, busy1} !== 2'b01) begin
            errors++; $display("FAIL rerun_accept: got done,busy=%b expected 01", {done1, busy1});
        end
        wait_done(1'b0, 20000, cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != e.cycles || pass1 !== e.pass) begin
            errors++; $display("FAIL rerun_result: got cycles=%0d pass=%b expected cycles=%0d pass=%b", cyc, pass1, e.cycles, e.pass);
        end
    endtask

    task automatic test_rdlat3();
        exp_t e;
        int cyc, v0;
        bit to;
        sb.push_back('{12800, 1'b1, 9'h0, 8'h0, 8'h0, 0});
        v0 = viol3;
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        wait_done(1'b1, 30000, cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != e.cycles) begin
            errors++; $display("FAIL lat3_cycles: got %0d (timeout=%0b) expected %0d", cyc, to, e.cycles);
        end
        checks++;
        if (pass3 !== e.pass || fail_addr3 !== e.addr) begin
            errors++; $display("FAIL lat3_result: got pass=%b addr=%h act=%h expected pass=%b addr=%h", pass3, fail_addr3, fail_act3, e.pass, e.addr);
        end
        checks++;
        if (viol3 != v0) begin errors++; $display("FAIL lat3_rwait_cen: got %0d cen-low cycles expected 0", viol3 - v0); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_stuck_bit();
        test_mid_reset();
        test_back_to_back();
        test_rdlat3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
